// File: rtl/prog_freq_divider.sv
// Runtime-programmable divided clock / clock-enable generator with handshaked config loads.
// Optional FREQ_DIV_SYNC_EN adds a sync_in phase-realign strobe.
module prog_freq_divider #(
  parameter int          WIDTH        = 26,
  parameter int unsigned DEFAULT_DIV  = 1350000,
  parameter int unsigned DEFAULT_HIGH = 675000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic             cfg_load,
`ifdef FREQ_DIV_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {STOPPED = 1'b0, RUN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] div_reg, high_reg;
  logic [WIDTH-1:0] pend_div_reg, pend_high_reg;
  logic             pend_valid_reg;
  logic [WIDTH-1:0] count_next;
  logic             clk_out_next, tick_next;
  logic             apply, wrap, load_ok, resync;

`ifdef FREQ_DIV_SYNC_EN
  assign resync = sync_in;
`else
  assign resync = 1'b0;
`endif

  assign wrap    = (count == div_reg - WIDTH'(1));
  assign load_ok = (cfg_div >= WIDTH'(2)) && (cfg_high <= cfg_div);

  // Pending config is only ever applied while count restarts at 0, so the
  // new period always begins cleanly with the new values.
  always_comb begin
    state_next   = state_reg;
    count_next   = '0;
    clk_out_next = 1'b0;
    tick_next    = 1'b0;
    apply        = 1'b0;
    case (state_reg)
      STOPPED: begin
        apply = pend_valid_reg;
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_next = STOPPED;
        end else begin
          clk_out_next = (count < high_reg);
          tick_next    = wrap;
          if (wrap || resync) apply = pend_valid_reg;
          else count_next = count + WIDTH'(1);
        end
      end
      default: state_next = STOPPED;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg      <= STOPPED;
      count          <= '0;
      clk_out        <= 1'b0;
      tick           <= 1'b0;
      cfg_ack        <= 1'b0;
      cfg_err        <= 1'b0;
      div_reg        <= WIDTH'(DEFAULT_DIV);
      high_reg       <= WIDTH'(DEFAULT_HIGH);
      pend_div_reg   <= '0;
      pend_high_reg  <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count     <= count_next;
      clk_out   <= clk_out_next;
      tick      <= tick_next;
      cfg_ack   <= apply;
      cfg_err   <= cfg_load && !load_ok;
      if (apply) begin
        div_reg  <= pend_div_reg;
        high_reg <= pend_high_reg;
      end
      // A load coinciding with application becomes the next pending config.
      if (cfg_load && load_ok) begin
        pend_div_reg   <= cfg_div;
        pend_high_reg  <= cfg_high;
        pend_valid_reg <= 1'b1;
      end else if (apply) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed bench for prog_freq_divider (WIDTH=8, DEFAULT_DIV=10, DEFAULT_HIGH=5)
// with a per-cycle expected-result queue compared after each edge.
module tb_prog_freq_divider;

  logic       clk_in = 1'b0;
  logic       reset, enable, cfg_load, sync_in;
  logic [7:0] cfg_div, cfg_high;
  logic       cfg_ack, cfg_err, clk_out, tick;
  logic [7:0] count;

  prog_freq_divider #(.WIDTH(8), .DEFAULT_DIV(10), .DEFAULT_HIGH(5)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_load(cfg_load),
`ifdef FREQ_DIV_SYNC_EN
    .sync_in(sync_in),
`endif
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick), .count(count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] count;
    logic       clk_out;
    logic       tick;
    logic       ack;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;
  int acks_seen = 0;
  int errs_seen = 0;

  // Reference state of the divider
  logic       m_run, m_pv;
  logic [7:0] m_count, m_div, m_high, m_pd, m_ph;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("count", 32'(count), 32'(e.count));
      check("clk_out", 32'(clk_out), 32'(e.clk_out));
      check("tick", 32'(tick), 32'(e.tick));
      check("cfg_ack", 32'(cfg_ack), 32'(e.ack));
      check("cfg_err", 32'(cfg_err), 32'(e.err));
    end
    if (tick === 1'b1) ticks_seen++;
    if (cfg_ack === 1'b1) acks_seen++;
    if (cfg_err === 1'b1) errs_seen++;
    $display("t=%0t en=%0b ld=%0b div=%0d high=%0d sync=%0b -> count=%0d clk_out=%0b tick=%0b ack=%0b err=%0b",
             $time, enable, cfg_load, cfg_div, cfg_high, sync_in, count, clk_out, tick, cfg_ack, cfg_err);
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; sync_in = 1'b0;
    cfg_div = 8'd0; cfg_high = 8'd0;
    m_run = 1'b0; m_pv = 1'b0; m_count = 8'd0; m_div = 8'd10; m_high = 8'd5;
    m_pd = 8'd0; m_ph = 8'd0;
    e = '0;
    exp_q.push_back(e);
    @(posedge clk_in); #1;
    compare_pop();
    reset = 1'b0;
  endtask

  task automatic step(input logic en, input logic ld, input logic [7:0] d,
                      input logic [7:0] h, input logic sy);
    exp_t e;
    logic apply, valid, wrap;
    enable = en; cfg_load = ld; cfg_div = d; cfg_high = h; sync_in = sy;
    e = '0;
    apply = 1'b0;
    e.err = ld && !((d >= 8'd2) && (h <= d));
    valid = ld && !e.err;
    if (!m_run) begin
      apply = m_pv;
      m_run = en;
    end else if (!en) begin
      m_run = 1'b0;
      m_count = 8'd0;
    end else begin
      e.clk_out = (m_count < m_high);
      wrap = (m_count == m_div - 8'd1);
      e.tick = wrap;
`ifdef FREQ_DIV_SYNC_EN
      if (wrap || sy) begin
`else
      if (wrap) begin
`endif
        m_count = 8'd0;
        apply = m_pv;
      end else begin
        m_count = m_count + 8'd1;
      end
    end
    e.count = m_count;
    e.ack = apply;
    if (apply) begin
      m_div = m_pd; m_high = m_ph;
    end
    if (valid) begin
      m_pd = d; m_ph = h; m_pv = 1'b1;
    end else if (apply) begin
      m_pv = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge clk_in); #1;
    compare_pop();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  // Bounded advance until the DUT count reaches the target value
  task automatic run_until(input logic [7:0] target);
    int n = 0;
    while (count !== target && n < 20) begin
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      n++;
    end
    check("reach_count", 32'(count), 32'(target));
  endtask

  initial begin
    int t0, a0, e0;
    do_reset();
    do_reset();

    // Default 10-cycle period, 5 high
    t0 = ticks_seen;
    run(31);
    check("default_ticks", 32'(ticks_seen - t0), 32'd3);

    // Mid-period load div=4 high=1
    run_until(8'd3);
    a0 = acks_seen;
    step(1'b1, 1'b1, 8'd4, 8'd1, 1'b0);
    run(16);
    check("load_ack_count", 32'(acks_seen - a0), 32'd1);

    // Rejected loads
    a0 = acks_seen; e0 = errs_seen;
    step(1'b1, 1'b1, 8'd1, 8'd0, 1'b0);
    run(2);
    step(1'b1, 1'b1, 8'd6, 8'd7, 1'b0);
    run(8);
    check("err_count", 32'(errs_seen - e0), 32'd2);
    check("err_no_ack", 32'(acks_seen - a0), 32'd0);

    // Two loads before one wrap; last wins
    run_until(8'd0);
    a0 = acks_seen;
    step(1'b1, 1'b1, 8'd6, 8'd2, 1'b0);
    step(1'b1, 1'b1, 8'd8, 8'd4, 1'b0);
    run(20);
    check("double_load_acks", 32'(acks_seen - a0), 32'd1);

    // Stop at count 6, load while stopped, restart with high == div
    run_until(8'd6);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    a0 = acks_seen;
    step(1'b0, 1'b1, 8'd3, 8'd3, 1'b0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    check("stopped_ack", 32'(acks_seen - a0), 32'd1);
    t0 = ticks_seen;
    run(10);
    check("div3_ticks", 32'(ticks_seen - t0), 32'd3);

    // Minimum period with constant-low output
    step(1'b1, 1'b1, 8'd2, 8'd0, 1'b0);
    run(8);

    // Reset with a pending load discards it
    run_until(8'd0);
    step(1'b1, 1'b1, 8'd5, 8'd2, 1'b0);
    do_reset();
    a0 = acks_seen;
    run(25);
    check("reset_discard_ack", 32'(acks_seen - a0), 32'd0);

`ifdef FREQ_DIV_SYNC_EN
    run_until(8'd4);
    t0 = ticks_seen;
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    check("sync_no_tick", 32'(ticks_seen - t0), 32'd0);
    run(10);
    check("sync_next_tick", 32'(ticks_seen - t0), 32'd1);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_freq_divider.md
Name: prog_freq_divider

Overview:
Runtime-programmable clock-enable/divided-clock generator and parametrised successor of the fixed divider. Divisor and high-time (duty) are loaded through a strobe/ack handshake and applied glitch-free only at period boundaries. Adds an enable gate, a per-period tick pulse and config error reporting. Feeds button debounce, scan and blink timing logic.

Parameters:
WIDTH, 26, counter/config width in bits
DEFAULT_DIV, 1350000, period in clk_in cycles after reset (2 .. 2^WIDTH-1)
DEFAULT_HIGH, 675000, clk_out high cycles per period after reset (0 .. DEFAULT_DIV)

Ports:
clk_in  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = run, 0 = stopped
cfg_div  input  WIDTH  requested period
cfg_high  input  WIDTH  requested high cycles
cfg_load  input  1  one-cycle strobe; samples cfg_div/cfg_high
cfg_ack  output  1  one-cycle pulse when a loaded config becomes active
cfg_err  output  1  one-cycle pulse when a load is rejected
clk_out  output  1  divided clock (registered)
tick  output  1  one-cycle pulse on the last cycle of each period
count  output  WIDTH  current phase counter

Behaviour:
- One clock (clk_in); reset synchronous, active-high. Every register changes only on posedge clk_in.
- Reset: count=0, clk_out=0, tick=0, cfg_ack=0, cfg_err=0. Active div_r=DEFAULT_DIV, high_r=DEFAULT_HIGH. Pending flag cleared. State=STOPPED.
- States:
  - STOPPED: count held at 0; clk_out=0; tick=0.
  - RUN: counting.
  - STOPPED->RUN when enable=1. RUN->STOPPED when enable=0; takes effect the same edge, so count=0 and clk_out=0 next cycle.
- RUN counting: count increments by 1. When count==div_r-1 ("wrap"), count<=0 instead.
- clk_out <= (count < high_r), evaluated on the current count, so clk_out lags count by 1 cycle.
  - high_r=0 gives constant low.
  - high_r=div_r gives constant high.
- tick <= 1 on the edge where wrap occurs, else 0.
- Load:
  - On cfg_load=1, validate: cfg_div>=2 and cfg_high<=cfg_div.
  - Invalid: cfg_err=1 next cycle; pending is untouched.
  - Valid: capture into pend_div/pend_high and set the pending flag. A later load before application overwrites it (last wins; only one ack results).
- Application:
  - RUN: pending is copied to div_r/high_r on the wrap edge. The new period starts at count=0 with the new values.
  - STOPPED: applied on the next edge.
  - cfg_ack=1 on the cycle after the copy edge. Pending flag clears on the copy edge.
- Simultaneous load and application edge: the old pending is applied (ack), and the new load becomes pending. Simultaneous load and wrap with nothing pending: the new load is captured only, and is applied at the following wrap.
- Reset mid-period or with a load pending: discards the pending config, restores defaults, and produces no ack.
- Width: count compare is unsigned WIDTH bits. No arithmetic overflow is possible because div_r-1 >= 1.

Optional Feature:
FREQ_DIV_SYNC_EN
- Defined:
  - Adds port sync_in (input, 1): a phase-realign strobe.
  - In RUN, sync_in=1 forces count<=0 on that edge.
  - tick is not asserted for the truncated period.
  - A pending config is applied on that edge, with cfg_ack as normal.
  - In STOPPED, sync_in is ignored.
  - sync_in on the same edge as wrap behaves as a normal wrap, with tick=1.
- Undefined: the port is absent and the logic is removed. Behaviour is exactly as above.

Test Plan (WIDTH=8, DEFAULT_DIV=10, DEFAULT_HIGH=5):
- Reset, enable=1 for 30 cycles -> count 0..9 repeating; clk_out high 5 / low 5, lagging count by 1; tick on every count==9 edge (3 pulses).
- Mid-period (count=3) load div=4, high=1 -> old 10-cycle period completes; count then cycles 0..3; clk_out 1 high/3 low; cfg_ack 1 cycle after the wrap.
- Load div=1 and separately div=6, high=7 -> cfg_err pulse each; period and duty unchanged; no cfg_ack.
- Two loads (div=6 then div=8) before a wrap -> single cfg_ack; period becomes 8.
- enable=0 at count=6, then load div=3, high=3 -> count=0 and clk_out=0 next cycle; ack 2 cycles after load; on re-enable, clk_out constant 1 and tick every 3 cycles.
- With FREQ_DIV_SYNC_EN: sync_in at count=4 -> count=0 next cycle; no tick for the truncated period; next tick 10 cycles later.
